// File: rtl/uart_tx_ctrl.sv
// UART TX controller: frames a byte (start, 8 data bits LSB-first, stop) and sequences the TX shift register.
// Define UART_TX_HOLD_EN to add a one-entry holding register so frames can run back-to-back.
module uart_tx_ctrl #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned CNT_W        = 16
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic [7:0] Tx_data,
   input  logic       Tx_valid,
   output logic       Tx_ready,
   output logic [9:0] Data_reg_out,
   output logic       Load_shift_register,
   output logic       Start,
   output logic       Shift_en,
   output logic       Busy,
   output logic       Frame_done
);

   typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

   state_t           state;
   logic [CNT_W-1:0] baud_cnt;
   logic [3:0]       bit_cnt;
   logic             take;

`ifdef UART_TX_HOLD_EN
   logic             hold_full;
   logic [7:0]       hold_data;
`endif

   assign take = Tx_valid && Tx_ready;

   // Frame bit 9 leaves the shift register first, so data goes in reversed.
   function automatic logic [9:0] frame(input logic [7:0] d);
      logic [7:0] rev;
      rev = {<<{d}};
      return {1'b0, rev, 1'b1};
   endfunction

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state               <= IDLE;
         baud_cnt            <= '0;
         bit_cnt             <= '0;
         Tx_ready            <= 1'b0;
         Data_reg_out        <= '1;
         Load_shift_register <= 1'b0;
         Start               <= 1'b0;
         Shift_en            <= 1'b0;
         Busy                <= 1'b0;
         Frame_done          <= 1'b0;
`ifdef UART_TX_HOLD_EN
         hold_full           <= 1'b0;
         hold_data           <= '0;
`endif
      end else begin
         Load_shift_register <= 1'b0;
         Shift_en            <= 1'b0;
         Frame_done          <= 1'b0;
`ifdef UART_TX_HOLD_EN
         if (take && state != IDLE) begin
            hold_data <= Tx_data;
            hold_full <= 1'b1;
            Tx_ready  <= 1'b0;
         end
`endif
         case (state)
            IDLE: begin
               Tx_ready <= 1'b1;
               if (take) begin
                  Data_reg_out        <= frame(Tx_data);
                  Load_shift_register <= 1'b1;
                  Busy                <= 1'b1;
                  state               <= LOAD;
`ifndef UART_TX_HOLD_EN
                  Tx_ready            <= 1'b0;
`endif
               end
            end
            LOAD: begin
               Start    <= 1'b1;
               baud_cnt <= '0;
               bit_cnt  <= '0;
               state    <= SEND;
            end
            SEND: begin
               if (baud_cnt == BAUD_LAST) begin
                  baud_cnt <= '0;
                  if (bit_cnt < 4'd9) begin
                     Shift_en <= 1'b1;
                     bit_cnt  <= bit_cnt + 4'd1;
                  end else begin
                     Frame_done <= 1'b1;
                     Start      <= 1'b0;
                     bit_cnt    <= '0;
`ifdef UART_TX_HOLD_EN
                     // A byte arriving on this very edge bypasses the (empty) holding
                     // register; these assignments override the capture above.
                     if (hold_full || take) begin
                        Data_reg_out        <= frame(hold_full ? hold_data : Tx_data);
                        Load_shift_register <= 1'b1;
                        hold_full           <= 1'b0;
                        Tx_ready            <= 1'b1;
                        state               <= LOAD;
                     end else begin
                        Busy     <= 1'b0;
                        Tx_ready <= 1'b1;
                        state    <= IDLE;
                     end
`else
                     Busy     <= 1'b0;
                     Tx_ready <= 1'b1;
                     state    <= IDLE;
`endif
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: random bytes on two instances (4 and 2 clocks per bit), checked against a
// frame timeline derived from the accept cycle and a serial-line decoder fed by a shift-register model.
module tb_uart_tx_ctrl;

   localparam int CPB_A = 4;
   localparam int CPB_B = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] tx_data = '0;
   logic       tx_valid = 1'b0;
   logic       sel = 1'b0;

   logic       ready_a, load_a, start_a, shift_a, busy_a, done_a;
   logic       ready_b, load_b, start_b, shift_b, busy_b, done_b;
   logic [9:0] dro_a, dro_b;
   logic [9:0] sr_a = '1, sr_b = '1;

   logic [5:0] flags;
   logic [9:0] dro;
   logic       serial;

   int unsigned n_checks = 0;
   int unsigned n_pass = 0;

   always #5 clk = ~clk;

   uart_tx_ctrl #(.CLKS_PER_BIT(CPB_A), .CNT_W(16)) u_dut_a (
      .Clk(clk), .Reset_n(rst_n), .Tx_data(tx_data), .Tx_valid(tx_valid && !sel),
      .Tx_ready(ready_a), .Data_reg_out(dro_a), .Load_shift_register(load_a),
      .Start(start_a), .Shift_en(shift_a), .Busy(busy_a), .Frame_done(done_a));

   uart_tx_ctrl #(.CLKS_PER_BIT(CPB_B), .CNT_W(16)) u_dut_b (
      .Clk(clk), .Reset_n(rst_n), .Tx_data(tx_data), .Tx_valid(tx_valid && sel),
      .Tx_ready(ready_b), .Data_reg_out(dro_b), .Load_shift_register(load_b),
      .Start(start_b), .Shift_en(shift_b), .Busy(busy_b), .Frame_done(done_b));

   // Downstream shift register: load the frame, shift left filling with idle-high.
   always @(posedge clk) begin
      if (load_a) sr_a <= dro_a; else if (shift_a) sr_a <= {sr_a[8:0], 1'b1};
      if (load_b) sr_b <= dro_b; else if (shift_b) sr_b <= {sr_b[8:0], 1'b1};
   end

   assign flags  = sel ? {ready_b, load_b, start_b, shift_b, busy_b, done_b}
                       : {ready_a, load_a, start_a, shift_a, busy_a, done_a};
   assign dro    = sel ? dro_b : dro_a;
   assign serial = sel ? sr_b[9] : sr_a[9];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Line order: start bit, data LSB first, stop bit; bit j on the line is frame bit 9-j.
   function automatic logic [9:0] ref_frame(input logic [7:0] d);
      logic [9:0] line_bits;
      logic [9:0] f;
      line_bits = {1'b1, d, 1'b0};
      for (int j = 0; j < 10; j++) f[4'(9 - j)] = line_bits[4'(j)];
      return f;
   endfunction

   // Expected {ready, load, start, shift, busy, done} t cycles after the accepting edge.
   function automatic logic [5:0] exp_flags(input int t, input int c);
      logic rdy, ld, st, sh, bs, dn;
      ld = (t == 1);
      st = (t >= 2) && (t <= 1 + 10 * c);
      sh = (t > 2) && (t <= 2 + 9 * c) && ((t - 2) % c == 0);
      bs = (t >= 1) && (t <= 1 + 10 * c);
      dn = (t == 2 + 10 * c);
`ifdef UART_TX_HOLD_EN
      rdy = 1'b1;
`else
      rdy = (t >= 2 + 10 * c);
`endif
      return {rdy, ld, st, sh, bs, dn};
   endfunction

   // Called at a negedge; returns at the negedge of the Frame_done cycle (or after an abort).
   task automatic send_frame(input logic [7:0] d, input bit noise, input int abort_t);
      int c = sel ? CPB_B : CPB_A;
      int last = 2 + 10 * c;
      int waited = 0;
      logic [9:0] line = '1;
      tx_data  = d;
      tx_valid = 1'b1;
      while (!flags[5]) begin
         if (waited++ > 100) begin
            check("ready_timeout", 32'd0, 32'd1);
            tx_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      @(negedge clk);
      tx_valid = 1'b0;
      for (int t = 1; t <= last; t++) begin
         if (t == abort_t) begin
            rst_n = 1'b0;
            #1;
            check("abort_flags", 32'(flags), 32'd0);
            check("abort_frame", 32'(dro), 32'h3FF);
            @(negedge clk);
            rst_n = 1'b1;
            #1;
            check("release_ready", 32'(flags), 32'd0);
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               check("post_abort", 32'(flags), 32'h20);
            end
            return;
         end
         check("timeline", 32'(flags), 32'(exp_flags(t, c)));
         check("frame", 32'(dro), 32'(ref_frame(d)));
         if (t >= 2 && t < 2 + 10 * c && (t - 2) % c == c / 2) line[4'((t - 2) / c)] = serial;
         if (noise && t < last) begin
            tx_valid = 1'b1;
            tx_data  = 8'($urandom);
         end else begin
            tx_valid = 1'b0;
         end
         if (t < last) @(negedge clk);
      end
      tx_valid = 1'b0;
      check("serial", 32'(line), 32'({1'b1, d, 1'b0}));
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("reset_flags", 32'(flags), 32'd0);
      check("reset_frame", 32'(dro), 32'h3FF);
      rst_n = 1'b1;
      #1;
      check("release_flags", 32'(flags), 32'd0);
      @(negedge clk);
      check("ready_after_reset", 32'(flags), 32'h20);

      send_frame(8'hA5, 1'b0, -1);
      check("frame_a5", 32'(dro), 32'h14B);
      send_frame(8'h00, 1'b0, -1);
      check("frame_00", 32'(dro), 32'h001);
      send_frame(8'hFF, 1'b0, -1);
      check("frame_ff", 32'(dro), 32'h1FF);
`ifndef UART_TX_HOLD_EN
      send_frame(8'($urandom), 1'b1, -1);
`endif
      send_frame(8'($urandom), 1'b0, 2 + 5 * CPB_A + 1);
      for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1'b0, -1);

      sel = 1'b1;
      @(negedge clk);
      send_frame(8'hA5, 1'b0, -1);
      for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b0, -1);

`ifdef UART_TX_HOLD_EN
      begin
         logic [7:0] hq [3];
         int idx = 0;
         int nl = 0;
         int c = CPB_A;
         logic [3:0] e;
         sel = 1'b0;
         @(negedge clk);
         for (int i = 0; i < 3; i++) hq[i] = 8'($urandom);
         for (int t = 0; t <= 4 + 30 * c; t++) begin
            e[3] = (t <= 1) || (t == 2 + 10 * c) || (t >= 3 + 20 * c);
            e[2] = (t == 1) || (t == 2 + 10 * c) || (t == 3 + 20 * c);
            e[1] = (t >= 2 && t <= 1 + 10 * c) || (t >= 3 + 10 * c && t <= 2 + 20 * c)
                   || (t >= 4 + 20 * c && t <= 3 + 30 * c);
            e[0] = (t == 2 + 10 * c) || (t == 3 + 20 * c) || (t == 4 + 30 * c);
            check("hold_timeline", 32'({flags[5], flags[4], flags[3], flags[0]}), 32'(e));
            if (flags[4] && nl < 3) begin
               check("hold_frame", 32'(dro), 32'(ref_frame(hq[nl])));
               nl++;
            end
            tx_valid = (idx < 3);
            tx_data  = hq[idx < 3 ? idx : 2];
            if (tx_valid && flags[5]) idx++;
            @(negedge clk);
         end
         tx_valid = 1'b0;
         check("hold_loads", 32'(nl), 32'd3);
      end
`endif

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
